// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared types, funct3 encodings and access-legality helper for the memory-stage LSU
package mem_lsu_pkg;
    localparam int LSU_XLEN = 32;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} lsu_state_e;
    typedef struct packed {
        logic                we;
        logic [2:0]          funct3;
        logic [LSU_XLEN-1:0] addr;
        logic [LSU_XLEN-1:0] wdata;
    } lsu_req_t;
    // Size must exist for the access kind and the offset must be naturally aligned.
    function automatic logic lsu_ok(input logic we, input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_B:    return 1'b1;
            F3_H:    return !off[0];
            F3_W:    return off == 2'b00;
            F3_BU:   return !we;
            F3_HU:   return !we && !off[0];
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: byte/halfword lane select with sign or zero extension of a read word
module lsu_load_align
    import mem_lsu_pkg::*;
(
    input  logic [LSU_XLEN-1:0] rdata,
    input  logic [1:0]          off,
    input  logic [2:0]          funct3,
    output logic [LSU_XLEN-1:0] data
);
    logic [7:0]  b;
    logic [15:0] h;
    always_comb begin
        b    = rdata[{off, 3'b000} +: 8];
        h    = off[1] ? rdata[31:16] : rdata[15:0];
        data = funct3[1] ? rdata :
               funct3[0] ? {{16{h[15] & ~funct3[2]}}, h} :
                           {{24{b[7] & ~funct3[2]}}, b};
    end
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: memory-stage load/store unit driving a req/rsp data bus and returning extended load data.
// Optional bus watchdog enabled by defining MEM_LSU_TIMEOUT_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN           = LSU_XLEN,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic            in_load,
    input  logic            in_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            flush,
    output logic            stall,
    output logic            ld_valid,
    output logic [XLEN-1:0] ld_data,
    output logic            fault,
    output logic            dmem_req_valid,
    input  logic            dmem_req_ready,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [3:0]      dmem_wstrb,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_rsp_valid,
    input  logic [XLEN-1:0] dmem_rdata
);
    lsu_state_e      state;
    lsu_req_t        req;
    logic            killed, ld_valid_q, fault_q;
    logic [XLEN-1:0] ld_q, al_data;
    logic            start, legal, hs, rsp, to;

    assign start = in_valid & (in_load | in_store) & ~flush;
    assign legal = lsu_ok(in_store, in_funct3, in_addr[1:0]);
    assign hs    = (state == REQ) & dmem_req_ready;
    assign rsp   = (state == WAIT_RSP) & dmem_rsp_valid;

`ifdef MEM_LSU_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] cnt;
    logic          busy;
    assign busy = ((state == REQ) & ~hs) | ((state == WAIT_RSP) & ~rsp);
    assign to   = busy & (cnt == CW'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk or negedge reset)
        if (!reset) cnt <= '0;
        else        cnt <= busy ? cnt + 1'b1 : '0;
`else
    logic unused_to;
    assign to        = 1'b0;
    assign unused_to = ^TIMEOUT_CYCLES;
`endif

    lsu_load_align u_align (
        .rdata  (dmem_rdata),
        .off    (req.addr[1:0]),
        .funct3 (req.funct3),
        .data   (al_data)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            req        <= '0;
            killed     <= 1'b0;
            ld_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            ld_q       <= '0;
        end else begin
            ld_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            case (state)
                IDLE: if (start && legal) begin
                    state  <= REQ;
                    req    <= '{in_store, in_funct3, in_addr, in_wdata};
                    killed <= 1'b0;
                end
                REQ: if (flush && !hs) state <= IDLE;
                else if (to) begin
                    state   <= DONE;
                    fault_q <= 1'b1;
                    ld_q    <= '0;
                end else if (hs) begin
                    state  <= req.we ? DONE : WAIT_RSP;
                    killed <= flush;
                end
                WAIT_RSP: if (rsp) begin
                    state <= DONE;
                    if (!(killed || flush)) begin
                        ld_valid_q <= 1'b1;
                        ld_q       <= al_data;
                    end
                end else if (to) begin
                    state   <= DONE;
                    fault_q <= 1'b1;
                    ld_q    <= '0;
                end else if (flush) killed <= 1'b1;
                DONE: state <= IDLE;
            endcase
        end
    end

    // Combinational terms are gated by reset so every output reads 0 while it is held.
    always_comb begin
        stall          = reset & (((state == IDLE) & start & legal) | (state == REQ) | (state == WAIT_RSP));
        fault          = fault_q | (reset & (state == IDLE) & start & ~legal);
        ld_valid       = ld_valid_q;
        ld_data        = ld_q;
        dmem_req_valid = state == REQ;
        dmem_we        = dmem_req_valid & req.we;
        dmem_addr      = dmem_req_valid ? {req.addr[XLEN-1:2], 2'b00} : '0;
        dmem_wstrb     = !dmem_we        ? 4'b0000 :
                         req.funct3[1]   ? 4'b1111 :
                         req.funct3[0]   ? 4'b0011 << req.addr[1:0] :
                                           4'b0001 << req.addr[1:0];
        dmem_wdata     = !dmem_we        ? '0 :
                         req.funct3[1]   ? req.wdata :
                         req.funct3[0]   ? {2{req.wdata[15:0]}} :
                                           {4{req.wdata[7:0]}};
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: table-driven load/store vectors plus hand-written flush, fault and reset sequences for mem_lsu
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid, in_load, in_store, flush;
    logic [2:0]  in_funct3;
    logic [31:0] in_addr, in_wdata;
    logic        stall, ld_valid, fault;
    logic [31:0] ld_data;
    logic        dmem_req_valid, dmem_req_ready, dmem_we, dmem_rsp_valid;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_wstrb;

    always #5 clk = ~clk;

    mem_lsu #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_load(in_load), .in_store(in_store),
        .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
        .flush(flush), .stall(stall), .ld_valid(ld_valid), .ld_data(ld_data), .fault(fault),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata)
    );

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] exp;
    } ld_vec_t;

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          hold;
        logic [3:0]  strb;
        logic [31:0] exp;
    } st_vec_t;

    ld_vec_t lv[8];
    st_vec_t sv[4];
    int total = 0, passed = 0;
    int rq;
    bit seen;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic idle();
        in_valid = 0; in_load = 0; in_store = 0; flush = 0;
        in_funct3 = 3'b000; in_addr = 0; in_wdata = 0;
    endtask

    // Entered and left at posedge+1; the bench acts as a one-cycle-latency responder.
    task automatic run_load(input string nm, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] rd, input logic [31:0] exp);
        int st = 0;
        bit pend = 0, got = 0;
        in_valid = 1; in_load = 1; in_store = 0; in_funct3 = f3; in_addr = a;
        dmem_req_ready = 1; dmem_rdata = rd;
        for (int n = 0; n < 20 && !got; n++) begin
            dmem_rsp_valid = pend;
            pend = 0;
            #1;
            st += int'(stall);
            if (dmem_req_valid && dmem_req_ready) begin
                pend = 1;
                check({nm, "_addr"}, dmem_addr, {a[31:2], 2'b00});
            end
            if (ld_valid) begin
                got = 1;
                check({nm, "_data"}, ld_data, exp);
                in_valid = 0; in_load = 0;
            end
            @(posedge clk); #1;
        end
        dmem_rsp_valid = 0; dmem_req_ready = 0;
        check({nm, "_valid"}, 32'(got), 32'd1);
        check({nm, "_stall"}, st, 32'd3);
    endtask

    task automatic run_store(input string nm, input st_vec_t v);
        int reqs = 0, bad = 0, lvs = 0;
        bit hsd = 0, done = 0;
        in_valid = 1; in_load = 0; in_store = 1; in_funct3 = v.f3; in_addr = v.addr; in_wdata = v.wdata;
        for (int n = 0; n < 30 && !done; n++) begin
            dmem_req_ready = reqs >= v.hold;
            #1;
            lvs += int'(ld_valid);
            if (hsd) begin
                done = 1;
                check({nm, "_done_stall"}, 32'(stall), 32'd0);
                in_valid = 0; in_store = 0;
            end
            if (dmem_req_valid) begin
                reqs++;
                if (dmem_wstrb !== v.strb || dmem_wdata !== v.exp || dmem_we !== 1'b1 ||
                    dmem_addr !== {v.addr[31:2], 2'b00}) bad++;
                if (dmem_req_ready) hsd = 1;
            end
            @(posedge clk); #1;
        end
        dmem_req_ready = 0;
        check({nm, "_done"}, 32'(done), 32'd1);
        check({nm, "_fields"}, bad, 32'd0);
        check({nm, "_req_cycles"}, reqs, v.hold + 1);
        check({nm, "_no_ld_valid"}, lvs, 32'd0);
    endtask

    initial begin
        lv[0] = '{F3_W,  32'h100, 32'hDEADBEEF, 32'hDEADBEEF};
        lv[1] = '{F3_B,  32'h103, 32'h80112233, 32'hFFFFFF80};
        lv[2] = '{F3_BU, 32'h103, 32'h80112233, 32'h00000080};
        lv[3] = '{F3_H,  32'h102, 32'h80112233, 32'hFFFF8011};
        lv[4] = '{F3_HU, 32'h102, 32'h80112233, 32'h00008011};
        lv[5] = '{F3_B,  32'h100, 32'h80112233, 32'h00000033};
        lv[6] = '{F3_B,  32'h101, 32'h80112233, 32'h00000022};
        lv[7] = '{F3_H,  32'h100, 32'h1234F00D, 32'hFFFFF00D};
        sv[0] = '{F3_B, 32'h201, 32'h000000AB, 4, 4'b0010, 32'hABABABAB};
        sv[1] = '{F3_H, 32'h202, 32'h0000BEEF, 1, 4'b1100, 32'hBEEFBEEF};
        sv[2] = '{F3_W, 32'h200, 32'h12345678, 0, 4'b1111, 32'h12345678};
        sv[3] = '{F3_B, 32'h203, 32'h00000011, 2, 4'b1000, 32'h11111111};

        idle();
        dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
        in_valid = 1; in_load = 1; in_funct3 = F3_W; in_addr = 32'h100;
        #12;
        check("rst_stall", 32'(stall), 0);
        check("rst_fault", 32'(fault), 0);
        check("rst_ld_valid", 32'(ld_valid), 0);
        check("rst_ld_data", ld_data, 0);
        check("rst_req_valid", 32'(dmem_req_valid), 0);
        check("rst_addr", dmem_addr, 0);
        check("rst_wstrb", 32'(dmem_wstrb), 0);
        idle();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) run_load($sformatf("ld%0d", i), lv[i].f3, lv[i].addr, lv[i].rdata, lv[i].exp);
        for (int i = 0; i < 4; i++) run_store($sformatf("st%0d", i), sv[i]);

        // Misaligned word load faults in place with no bus activity.
        in_valid = 1; in_load = 1; in_funct3 = F3_W; in_addr = 32'h102;
        #1;
        check("mis_fault", 32'(fault), 1);
        check("mis_stall", 32'(stall), 0);
        check("mis_req", 32'(dmem_req_valid), 0);
        @(posedge clk); #1;
        check("mis_after_req", 32'(dmem_req_valid), 0);
        check("mis_after_fault", 32'(fault), 1);
        idle(); #1;
        check("mis_clear_fault", 32'(fault), 0);
        @(posedge clk); #1;
        in_valid = 1; in_store = 1; in_funct3 = F3_BU; in_addr = 32'h200;
        #1;
        check("ill_fault", 32'(fault), 1);
        check("ill_stall", 32'(stall), 0);
        idle();
        @(posedge clk); #1;
        check("ill_req", 32'(dmem_req_valid), 0);

        // Flush in the same cycle as a start: no access.
        in_valid = 1; in_load = 1; in_funct3 = F3_W; in_addr = 32'h140; flush = 1;
        #1;
        check("fl_start_stall", 32'(stall), 0);
        @(posedge clk); #1;
        idle(); #1;
        check("fl_start_req", 32'(dmem_req_valid), 0);

        // Flush in REQ before handshake abandons the request.
        in_valid = 1; in_load = 1; in_funct3 = F3_W; in_addr = 32'h180; dmem_req_ready = 0;
        @(posedge clk); #1;
        check("fl_req_valid", 32'(dmem_req_valid), 1);
        flush = 1;
        @(posedge clk); #1;
        idle(); #1;
        check("fl_req_dropped", 32'(dmem_req_valid), 0);
        check("fl_req_stall", 32'(stall), 0);
        @(posedge clk); #1;

        // Flush in WAIT_RSP: the response drains, ld_valid stays low, ld_data keeps its value.
        in_valid = 1; in_load = 1; in_funct3 = F3_W; in_addr = 32'h108; dmem_req_ready = 1;
        dmem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        check("flw_req", 32'(dmem_req_valid), 1);
        @(posedge clk); #1;
        dmem_req_ready = 0; flush = 1;
        #1;
        check("flw_stall_flush", 32'(stall), 1);
        @(posedge clk); #1;
        flush = 0; dmem_rsp_valid = 1;
        #1;
        check("flw_stall_drain", 32'(stall), 1);
        @(posedge clk); #1;
        dmem_rsp_valid = 0;
        #1;
        check("flw_ld_valid", 32'(ld_valid), 0);
        check("flw_stall_done", 32'(stall), 0);
        check("flw_ld_data", ld_data, lv[7].exp);
        @(posedge clk); #1;
        idle();
        run_load("after_flush", F3_W, 32'h104, 32'h0BADF00D, 32'h0BADF00D);

`ifdef MEM_LSU_TIMEOUT_EN
        in_valid = 1; in_load = 1; in_funct3 = F3_W; in_addr = 32'h300; dmem_req_ready = 0;
        rq = 0; seen = 0;
        for (int n = 0; n < 40 && !seen; n++) begin
            #1;
            if (fault) begin
                seen = 1;
                check("to_stall", 32'(stall), 0);
                check("to_ld_valid", 32'(ld_valid), 0);
                check("to_ld_data", ld_data, 0);
                idle();
            end else if (dmem_req_valid) rq++;
            @(posedge clk); #1;
        end
        check("to_seen", 32'(seen), 1);
        check("to_req_cycles", rq, 8);
        idle();
`endif

        // Asynchronous reset mid-REQ clears every output immediately.
        in_valid = 1; in_store = 1; in_funct3 = F3_B; in_addr = 32'h205; in_wdata = 32'h5A;
        dmem_req_ready = 0;
        @(posedge clk); #1;
        check("ar_req_before", 32'(dmem_req_valid), 1);
        reset = 0;
        #1;
        check("ar_req_valid", 32'(dmem_req_valid), 0);
        check("ar_stall", 32'(stall), 0);
        check("ar_addr", dmem_addr, 0);
        check("ar_wstrb", 32'(dmem_wstrb), 0);
        check("ar_we", 32'(dmem_we), 0);
        check("ar_ld_data", ld_data, 0);
        idle();
        @(posedge clk); #1;
        reset = 1;
        @(posedge clk); #1;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
